dot_acc_su: RTL and testbench
=============================

DOT_ACC_SU -- requirements
Module: dot_acc_su

Interface
REQ-001 Parameter: MAX_LEN, 16, maximum products per group (power of two, 2..16).
REQ-002 Parameter: ACC_W, 12, accumulator and result width in bits (signed, two's complement).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: in_prod  input  8  signed product from the upstream 4x4 signed x unsigned multiplier, range -120..+105.
REQ-006 Port: in_valid  input  1  in_prod/in_last valid this cycle.
REQ-007 Port: in_last  input  1  marks the final product of a group.
REQ-008 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-009 Port: out_sum  output  ACC_W  signed group sum.
REQ-010 Port: out_cnt  output  5  number of products in the reported group (1..MAX_LEN).
REQ-011 Port: out_trunc  output  1  group closed by the MAX_LEN limit, not by in_last.
REQ-012 Port: out_valid  output  1  out_sum/out_cnt/out_trunc valid.
REQ-013 Port: out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-014 A beat is accepted when in_valid && in_ready; no other cycle changes the accumulator.
REQ-015 in_ready shall be combinational: ~out_valid | out_ready; it shall not depend on in_valid.
REQ-016 The FSM shall have two states: IDLE (acc=0, cnt=0) and ACC (cnt 1..MAX_LEN-1).
REQ-017 Accepted beat that does not close the group: acc <= acc + sext(in_prod); cnt <= cnt+1; state <= ACC.
REQ-018 A beat closes the group when in_last=1 or cnt == MAX_LEN-1.
REQ-019 Accepted closing beat: out_sum <= acc + sext(in_prod); out_cnt <= cnt+1; out_trunc <= ~in_last; out_valid <= 1; acc, cnt <= 0; state <= IDLE.
REQ-020 Latency: out_valid rises in the cycle after the closing beat is accepted.
REQ-021 Result transfer occurs when out_valid && out_ready; without a new closing beat in the same cycle, out_valid <= 0.
REQ-022 Simultaneous result transfer and closing beat: the new result loads and out_valid stays 1, for 1 result/cycle throughput.
REQ-023 While out_valid=1 and out_ready=0, out_sum/out_cnt/out_trunc shall hold stable and no beat is accepted.
REQ-024 Arithmetic: sign-extend 8 to ACC_W bits; with MAX_LEN<=16 and ACC_W=12 no overflow occurs; no saturation logic.
REQ-025 A single-beat group (in_last on the first beat) reports out_sum = sext(in_prod), out_cnt = 1.
REQ-026 in_prod and in_last are ignored when the beat is not accepted.

Reset
REQ-027 On rst=1 at a clock edge: acc=0, cnt=0, state IDLE, out_sum=0, out_cnt=0, out_trunc=0, out_valid=0.
REQ-028 rst overrides any concurrent beat or transfer; a partial group in progress is discarded.
REQ-029 After reset in_ready=1, since it derives from out_valid=0.

Verification
REQ-030 Beats 0x05, 0xF8(-8), 0x69(+105, last) with out_ready=1 -> one cycle later out_valid=1, out_sum=102, out_cnt=3, out_trunc=0.
REQ-031 16 beats of 0x88(-120), in_last=0 -> out_sum=-1920 (0x880), out_cnt=16, out_trunc=1; next beat starts a new group from 0.
REQ-032 Group result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no beat lost; on out_ready=1 the stalled beat is accepted.
REQ-033 Back-to-back single-beat groups 0x01, 0x02, 0x03 with out_ready=1 -> out_valid held high for 3 consecutive cycles with sums 1, 2, 3.
REQ-034 rst asserted after 2 of 4 beats -> no result emitted; the next group of 0x0A (last) -> out_sum=10, out_cnt=1.
REQ-035 Random stimulus, random in_valid/out_ready -> every result matches a reference model of group sums, counts and trunc flags, in order.

Source files
------------

// File: rtl/dot_acc_su.sv
// Group accumulator for signed 8-bit products: sums beats until in_last or MAX_LEN,
// then presents {sum, count, trunc} on a valid/ready result port with 1 result/cycle throughput.
module dot_acc_su #(
    parameter int MAX_LEN = 16,
    parameter int ACC_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [7:0]       in_prod,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [4:0]              out_cnt,
    output logic                    out_trunc,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_nx_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [4:0]              cnt_r;
    logic [4:0]              cnt_nx_s;
    logic [4:0]              cnt_inc_s;
    logic                    accept_s;
    logic                    close_s;
    logic signed [ACC_W-1:0] out_sum_r;
    logic [4:0]              out_cnt_r;
    logic                    out_trunc_r;
    logic                    out_valid_r;

    // A slot is free whenever no result is held or the held one leaves this cycle.
    assign in_ready  = ~out_valid_r | out_ready;
    assign out_sum   = out_sum_r;
    assign out_cnt   = out_cnt_r;
    assign out_trunc = out_trunc_r;
    assign out_valid = out_valid_r;

    // Beat acceptance, running sum and group-close decision.
    always_comb begin
        accept_s  = in_valid & in_ready;
        sum_s     = acc_r + {{(ACC_W-8){in_prod[7]}}, in_prod};
        cnt_inc_s = cnt_r + 5'd1;
        close_s   = in_last | (cnt_r == 5'(MAX_LEN - 1));
    end

    // Next-state logic for the accumulator FSM.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE, ACC: begin
                if (accept_s) begin
                    if (close_s) begin
                        state_nx_s = IDLE;
                        acc_nx_s   = '0;
                        cnt_nx_s   = 5'd0;
                    end else begin
                        state_nx_s = ACC;
                        acc_nx_s   = sum_s;
                        cnt_nx_s   = cnt_inc_s;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
                acc_nx_s   = '0;
                cnt_nx_s   = 5'd0;
            end
        endcase
    end

    // FSM state and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= '0;
            cnt_r   <= 5'd0;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Result register: a closing beat loads even while the previous result transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum_r   <= '0;
            out_cnt_r   <= 5'd0;
            out_trunc_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s && close_s) begin
            out_sum_r   <= sum_s;
            out_cnt_r   <= cnt_inc_s;
            out_trunc_r <= ~in_last;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_dot_acc_su.sv
// Self-checking bench for dot_acc_su: directed scenarios plus random traffic,
// compared each cycle against a queue-based group-sum reference model.
module tb_dot_acc_su;

    localparam int MAX_LEN = 16;
    localparam int ACC_W   = 12;

    logic                    clk;
    logic                    rst;
    logic signed [7:0]       in_prod;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [4:0]              out_cnt;
    logic                    out_trunc;
    logic                    out_valid;
    logic                    out_ready;

    dot_acc_su #(.MAX_LEN(MAX_LEN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_trunc (out_trunc),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: the open group as a list of products, plus the held result.
    int grp[$];
    bit armed   = 1'b0;
    bit m_valid = 1'b0;
    bit m_zero  = 1'b0;
    int m_sum   = 0;
    int m_cnt   = 0;
    bit m_trunc = 1'b0;
    int results = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        nchk++;
        assert (got === 32'(exp)) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] p, input bit l, input bit ordy, input bit r);
        bit acc;
        int s;
        @(negedge clk);
        rst = r; in_valid = v; in_prod = p; in_last = l; out_ready = ordy;
        #1;
        if (armed) begin
            chk("in_ready", {31'd0, in_ready}, (!m_valid || ordy) ? 1 : 0);
            chk("out_valid", {31'd0, out_valid}, m_valid ? 1 : 0);
            if (m_valid || m_zero) begin
                chk("out_sum", 32'($signed(out_sum)), m_sum);
                chk("out_cnt", {27'd0, out_cnt}, m_cnt);
                chk("out_trunc", {31'd0, out_trunc}, m_trunc ? 1 : 0);
            end
        end
        if (r) begin
            grp.delete();
            armed = 1'b1; m_valid = 1'b0; m_zero = 1'b1;
            m_sum = 0; m_cnt = 0; m_trunc = 1'b0;
        end else begin
            acc = v && (!m_valid || ordy);
            if (acc) grp.push_back(int'($signed(p)));
            if (acc && (l || grp.size() == MAX_LEN)) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
                m_sum = s; m_cnt = grp.size(); m_trunc = !l;
                m_valid = 1'b1; m_zero = 1'b0; results++;
                grp.delete();
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("reset_in_ready", {31'd0, in_ready}, 1);

        // Three-beat group ending with the largest positive product.
        step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hF8, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h69, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("g3_sum", 32'($signed(out_sum)), 102);
        chk("g3_cnt", {27'd0, out_cnt}, 3);

        // Sixteen most-negative products closed by the length limit.
        for (int i = 0; i < 16; i++) step(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        chk("trunc_sum", 32'($signed(out_sum)), -1920);
        chk("trunc_cnt", {27'd0, out_cnt}, 16);
        chk("trunc_flag", {31'd0, out_trunc}, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("after_trunc_sum", 32'($signed(out_sum)), 7);

        // Held result with a stalled beat waiting, then release.
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        chk("stall_sum", 32'($signed(out_sum)), 17);
        step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("stall_release_sum", 32'($signed(out_sum)), 34);

        // Back-to-back single-beat groups.
        step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        chk("b2b_sum2", 32'($signed(out_sum)), 2);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("b2b_sum3", 32'($signed(out_sum)), 3);
        chk("b2b_valid3", {31'd0, out_valid}, 1);

        // Reset mid-group discards the partial sum.
        step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h30, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h0A, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("post_rst_sum", 32'($signed(out_sum)), 10);
        chk("post_rst_cnt", {27'd0, out_cnt}, 1);

        // Random traffic within the multiplier's product range.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] p;
            p = 8'($signed($urandom_range(225, 0)) - 120);
            step($urandom_range(3, 0) != 0, p, $urandom_range(9, 0) == 0,
                 $urandom_range(3, 0) != 0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
